// File: rtl/tile_pkg.sv
// Shared defaults and register-map constants for the CGRA tile operand register file.
package tile_pkg;

    localparam int WIDTH        = 16;
    localparam int NUM_INPUTS   = 4;
    localparam int TOTAL_INPUTS = 2 * NUM_INPUTS;

    typedef logic [WIDTH-1:0] data_t;

    localparam int BANK_A_BASE = 0;
    localparam int BANK_B_BASE = NUM_INPUTS;
    localparam int SCALAR_IDX  = TOTAL_INPUTS;

endpackage

// File: rtl/tile_regfile_bank.sv
// N-lane register group with a common load enable; loads on the enabled edge, one-cycle latency.
// No backpressure: an asserted enable always loads; the caller owns any gating.
module regfile_bank
    import tile_pkg::*;
#(
    parameter int width = WIDTH,
    parameter int lanes = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [lanes-1:0][width-1:0]  d,
    output logic [lanes-1:0][width-1:0]  q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tile_regfile.sv
// Tile operand register file: three disjoint write banks, registered snapshot read bus, write ack.
// Read wins: a ren cycle drops every write and returns the pre-edge contents one edge later.
module tile_regfile
    import tile_pkg::*;
#(
    parameter  int width        = WIDTH,
    parameter  int num_regs     = 16,
    parameter  int num_inputs   = NUM_INPUTS,
    localparam int total_inputs = 2 * num_inputs
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ren,
    input  logic                               wen1,
    input  logic                               wen2,
    input  logic                               wen3,
    input  logic [num_inputs-1:0][width-1:0]   w_data1,
    input  logic [num_inputs-1:0][width-1:0]   w_data2,
    input  logic [width-1:0]                   w_data3,
    output logic [total_inputs:0][width-1:0]   r_data,
    output logic                               wr_ack
);

    localparam int bank_a_base = BANK_A_BASE;
    localparam int bank_b_base = num_inputs;
    localparam int scalar_idx  = total_inputs;

    // Registers above scalar_idx are architecturally constant zero, so they get no storage.
    if (num_regs < total_inputs + 1) begin : g_num_regs_too_small
        $error("tile_regfile: num_regs must be at least 2*num_inputs+1");
    end

    logic [total_inputs:0][width-1:0] regs;
    logic                             wr_open;
    logic                             a_en;
    logic                             b_en;
    logic                             s_en;

    assign wr_open = ~ren;
    assign a_en    = wen1 & wr_open;
    assign b_en    = wen2 & wr_open;
    assign s_en    = wen3 & wr_open;

    regfile_bank #(.width(width), .lanes(num_inputs)) u_bank_a (
        .clk   (clk),
        .reset (reset),
        .en    (a_en),
        .d     (w_data1),
        .q     (regs[bank_a_base +: num_inputs])
    );

    regfile_bank #(.width(width), .lanes(num_inputs)) u_bank_b (
        .clk   (clk),
        .reset (reset),
        .en    (b_en),
        .d     (w_data2),
        .q     (regs[bank_b_base +: num_inputs])
    );

    regfile_bank #(.width(width), .lanes(1)) u_bank_s (
        .clk   (clk),
        .reset (reset),
        .en    (s_en),
        .d     (w_data3),
        .q     (regs[scalar_idx])
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            wr_ack <= 1'b0;
        end else begin
            if (ren) begin
                r_data <= regs;
            end
            wr_ack <= (wen1 | wen2 | wen3) & wr_open;
        end
    end

endmodule

// File: tb/tb_tile_regfile.sv
// Directed plus random bench for tile_regfile against an array-based reference model.
module tb_tile_regfile;
    import tile_pkg::*;

    localparam int NI = NUM_INPUTS;
    localparam int TI = TOTAL_INPUTS;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     ren, wen1, wen2, wen3;
    logic [NI-1:0][WIDTH-1:0] w_data1, w_data2;
    logic [WIDTH-1:0]         w_data3;
    logic [TI:0][WIDTH-1:0]   r_data;
    logic                     wr_ack;

    data_t mregs [TI+1];
    data_t mr    [TI+1];
    logic  mack;
    int    errors = 0;
    int    checks = 0;

    tile_regfile #(.width(WIDTH), .num_regs(16), .num_inputs(NI)) dut (
        .clk     (clk),
        .reset   (reset),
        .ren     (ren),
        .wen1    (wen1),
        .wen2    (wen2),
        .wen3    (wen3),
        .w_data1 (w_data1),
        .w_data2 (w_data2),
        .w_data3 (w_data3),
        .r_data  (r_data),
        .wr_ack  (wr_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j <= TI; j++) begin
            mregs[j] = '0;
            mr[j]    = '0;
        end
        mack = 1'b0;
    endtask

    // One clock edge as the register map describes it: a read snapshots, otherwise writes land.
    task automatic model_edge();
        mack = (wen1 | wen2 | wen3) & ~ren;
        if (ren) begin
            for (int j = 0; j <= TI; j++) mr[j] = mregs[j];
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (wen1) mregs[i]      = w_data1[i];
                if (wen2) mregs[NI + i] = w_data2[i];
            end
            if (wen3) mregs[TI] = w_data3;
        end
    endtask

    task automatic check_all(input string tag);
        for (int j = 0; j <= TI; j++) chk($sformatf("%s r_data[%0d]", tag, j), r_data[j], mr[j]);
        chk({tag, " wr_ack"}, {15'd0, wr_ack}, {15'd0, mack});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        ren = 0; wen1 = 0; wen2 = 0; wen3 = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        w_data1 = '0; w_data2 = '0; w_data3 = '0;
        model_clear();
        #10;
        check_all("reset");
        chk("reset r_data[8] const", r_data[8], 16'h0000);
        reset = 1'b0;

        // Bank A held for two edges, then banks B and S.
        wen1 = 1; w_data1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        step("wen1 a");
        chk("wen1 a ack const", {15'd0, wr_ack}, 16'h0001);
        step("wen1 b");
        wen1 = 0; wen2 = 1; wen3 = 1;
        w_data2 = {16'h9999, 16'h8888, 16'h7777, 16'h6666};
        w_data3 = 16'hBBBB;
        step("wen2_3");
        chk("wen2_3 ack const", {15'd0, wr_ack}, 16'h0001);

        idle(); ren = 1;
        step("read1");
        chk("read1 r0 const", r_data[0], 16'h1111);
        chk("read1 r3 const", r_data[3], 16'h4444);
        chk("read1 r4 const", r_data[4], 16'h6666);
        chk("read1 r7 const", r_data[7], 16'h9999);
        chk("read1 r8 const", r_data[8], 16'hBBBB);
        chk("read1 ack const", {15'd0, wr_ack}, 16'h0000);

        // Read bus holds across later writes while ren is low.
        ren = 0; wen2 = 1; w_data2 = {16'h1234, 16'h1234, 16'h1234, 16'h1234};
        step("hold a");
        idle();
        step("hold b");
        chk("hold r7 const", r_data[7], 16'h9999);

        wen1 = 1; wen2 = 1; wen3 = 1;
        w_data1 = {4{16'hCCCC}}; w_data2 = {4{16'hDDDD}}; w_data3 = 16'hEEEE;
        step("simul wr");
        idle(); ren = 1;
        step("simul rd");
        chk("simul r0 const", r_data[0], 16'hCCCC);
        chk("simul r4 const", r_data[4], 16'hDDDD);
        chk("simul r8 const", r_data[8], 16'hEEEE);

        // Read beats a concurrent write.
        ren = 1; wen1 = 1; w_data1[0] = 16'hFFFF;
        step("rd_blk wr");
        chk("rd_blk ack const", {15'd0, wr_ack}, 16'h0000);
        idle(); ren = 1;
        step("rd_blk rd");
        chk("rd_blk r0 const", r_data[0], 16'hCCCC);

        // Async reset between edges while a write is pending.
        idle(); wen1 = 1; w_data1 = {4{16'h5A5A}};
        step("pre_rst");
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        check_all("async rst");
        chk("async rst r0 const", r_data[0], 16'h0000);
        #1;
        reset = 1'b0;
        idle(); ren = 1;
        step("post_rst rd");

        for (int n = 0; n < 300; n++) begin
            ren  = ($urandom_range(0, 3) == 0);
            wen1 = $urandom_range(0, 1);
            wen2 = $urandom_range(0, 1);
            wen3 = $urandom_range(0, 1);
            for (int i = 0; i < NI; i++) begin
                w_data1[i] = WIDTH'($urandom);
                w_data2[i] = WIDTH'($urandom);
            end
            w_data3 = WIDTH'($urandom);
            step($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_regfile.md
# tile_regfile

CGRA tile operand register file. Three independent write ports (two vector ports of `num_inputs` lanes, one scalar port) load disjoint register banks. A single read-enable snapshots all operand registers onto a parallel registered read bus feeding the tile datapath. A one-cycle write acknowledge reports accepted writes back to the tile controller.

## Interface
- Module name is `tile_regfile`.
- One clock; reset is asynchronous and active-high.

Parameters:
- `width`, default 16: data width of every register.
- `num_regs`, default 16: physical register count. Must be ≥ 2·`num_inputs`+1.
- `num_inputs`, default 4: lanes per vector write port.
- Derived `total_inputs` = 2·`num_inputs` (8 by default).

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `ren`, input, 1: read enable; also blocks writes.
- `wen1`, input, 1: write enable for bank A.
- `wen2`, input, 1: write enable for bank B.
- `wen3`, input, 1: write enable for scalar register S.
- `w_data1`, input, `width` × [`num_inputs`]: bank A lane data.
- `w_data2`, input, `width` × [`num_inputs`]: bank B lane data.
- `w_data3`, input, `width`: scalar data.
- `r_data`, output, `width` × [`total_inputs`+1]: registered read bus, indices 0..`total_inputs`.
- `wr_ack`, output, 1: registered write acknowledge.

## Operation
- Register map:
  - Bank A: `regs[i]` for i = 0..`num_inputs`-1, written from `w_data1[i]`.
  - Bank B: `regs[num_inputs+i]`, written from `w_data2[i]`.
  - Scalar: `regs[total_inputs]`, written from `w_data3`.
  - `regs[total_inputs+1 .. num_regs-1]` are unused. They are held at 0 and never written.
- Write acceptance: `wenK` is accepted only when `ren`=0. `ren`=1 has priority, and all writes in that cycle are dropped.
- Simultaneous accepted writes on all three ports all commit in the same edge. The banks are disjoint, so no conflict exists.
- Read: on each edge with `ren`=1, `r_data[j]` ← `regs[j]` for j = 0..`total_inputs`. The value captured is the pre-edge register contents. With `ren`=0, `r_data` holds its last value.
- `wr_ack` ← (`wen1`|`wen2`|`wen3`) & ~`ren` every edge.

## Timing
- Reset (async assert, synchronous-safe release) forces to 0: all `regs`, all `r_data`, and `wr_ack`.
- Write latency: data is visible in `regs` after the accepting edge. It appears on `r_data` one edge after a subsequent `ren`=1 edge.
  - Write edge N, `ren` high at edge N+1 → `r_data` valid after N+1.
- `ren`=1 and `wen`=1 in the same cycle: the read returns old contents and the write is lost. `wr_ack`=0 for that cycle.
- `wr_ack` is high exactly for the cycle(s) following edges with an accepted write. It stays high continuously while `wen` is held.
- Held `wen`: the bank rewrites every edge; the last value wins.
- Reset mid-operation: state clears immediately. Any pending write is discarded.

## Structure
- Shared package `tile_pkg`:
  - default `WIDTH`, `NUM_INPUTS`, `TOTAL_INPUTS`.
  - `data_t` typedef (`logic [WIDTH-1:0]`).
  - bank base-index constants (`BANK_A_BASE`=0, `BANK_B_BASE`=`NUM_INPUTS`, `SCALAR_IDX`=`TOTAL_INPUTS`).
- One sub-module, `regfile_bank`: an N-lane register group with a common enable and async reset. It is instantiated for banks A, B and scalar S (N=1). The top adds the `ren` gating, read capture and `wr_ack`.

## Test plan
- Reset: assert `reset` 10 ns → all `r_data`=0000, `wr_ack`=0.
- Bank A write then read:
  - `wen1`=1 with 1111/2222/3333/4444, then `wen2`=1 with 6666/7777/8888/9999 and `wen3`=1 with BBBB; `wr_ack`=1 while enables are held.
  - Drop the enables and set `ren`=1 → `r_data[0..3]`=1111..4444, `r_data[4]`=6666, `r_data[7]`=9999, `r_data[8]`=BBBB; `wr_ack`=0.
- Read hold: after the read, `ren`=0 → `r_data[7]` stays 9999 regardless of later writes until the next `ren` edge.
- Simultaneous writes: one cycle of `wen1`/`wen2`/`wen3` with CCCC/DDDD/EEEE, then `ren`=1 → `r_data[0]`=CCCC, `r_data[4]`=DDDD, `r_data[8]`=EEEE.
- Read blocks write: `wen1`=1, `ren`=1, `w_data1[0]`=FFFF for one cycle, then read → `r_data[0]`=CCCC (unchanged); `wr_ack`=0.
- Async reset mid-write: assert `reset` between clock edges with `wen1` high → `regs`, `r_data` and `wr_ack` clear at once, before the next edge.
